gcd_datapath: RTL and testbench



---
 rtl/gcd_datapath_if.sv | 40 ++++
 rtl/gcd_datapath.sv | 67 ++++++
 tb/tb_gcd_datapath.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_datapath_if.sv
// Bundle for the GCD datapath: controller flags, the operand handshake,
// controller status and the result. Clock and reset stay outside.
//
// Operand handshake: a pair transfers on a rising edge where both
// operand_valid_i and operand_ready_o are 1. The sender holds the operands
// stable while valid is high. Ready never depends on valid.
interface gcd_datapath_if #(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 17
);
  logic              gcd_enable_i;
  logic              flag_init_i;
  logic              flag_compute_i;
  logic              flag_finish_i;
  logic [WIDTH-1:0]  operand_a_i;
  logic [WIDTH-1:0]  operand_b_i;
  logic              operand_valid_i;
  logic              operand_ready_o;
  logic              compute_enable_o;
  logic              compare_zero_o;
  logic [WIDTH-1:0]  result_o;
  logic              result_valid_o;
  logic [ITER_W-1:0] iter_count_o;

  // Controller / operand source side
  modport master (
    output gcd_enable_i, flag_init_i, flag_compute_i, flag_finish_i,
    output operand_a_i, operand_b_i, operand_valid_i,
    input  operand_ready_o, compute_enable_o, compare_zero_o,
    input  result_o, result_valid_o, iter_count_o
  );

  // Datapath side
  modport slave (
    input  gcd_enable_i, flag_init_i, flag_compute_i, flag_finish_i,
    input  operand_a_i, operand_b_i, operand_valid_i,
    output operand_ready_o, compute_enable_o, compare_zero_o,
    output result_o, result_valid_o, iter_count_o
  );
endinterface

// File: rtl/gcd_datapath.sv
// GCD datapath: loads one operand pair, runs subtractive Euclid steps while
// the controller is in COMPUTE, reports b==0 status back and presents the
// result in FINISH. Single-shot until the next reset.
module gcd_datapath #(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 17
) (
  input  logic          clk_i,
  input  logic          reset_i,
  gcd_datapath_if.slave bus
);

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              loaded_q;
  logic [ITER_W-1:0] iter_q;

  logic b_zero;
  logic ready;
  logic load_fire;
  logic step_fire;
  logic res_valid;

  // Status and strobe decode, purely from registers and current flags
  always_comb begin
    b_zero    = (b_q == '0);
    ready     = bus.flag_init_i & bus.gcd_enable_i & ~loaded_q;
    load_fire = bus.operand_valid_i & ready;
    // A step needs a loaded, non-zero divisor; once b reaches 0 the extra
    // COMPUTE cycle the controller spends before FINISH does nothing.
    step_fire = bus.flag_compute_i & bus.gcd_enable_i & loaded_q & ~b_zero;
    res_valid = bus.flag_finish_i & loaded_q & b_zero;
  end

  assign bus.operand_ready_o  = ready;
  assign bus.compute_enable_o = loaded_q & ~b_zero;
  assign bus.compare_zero_o   = loaded_q & b_zero;
  assign bus.result_valid_o   = res_valid;
  assign bus.result_o         = res_valid ? a_q : '0;
  assign bus.iter_count_o     = iter_q;

  // Operand load, Euclid step (subtract or swap) and saturating step count
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q      <= '0;
      b_q      <= '0;
      loaded_q <= 1'b0;
      iter_q   <= '0;
    end else if (load_fire) begin
      a_q      <= bus.operand_a_i;
      b_q      <= bus.operand_b_i;
      loaded_q <= 1'b1;
      iter_q   <= '0;
    end else if (step_fire) begin
      if (a_q >= b_q) begin
        a_q <= a_q - b_q;
      end else begin
        a_q <= b_q;
        b_q <= a_q;
      end
      if (iter_q != '1) begin
        iter_q <= iter_q + ITER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gcd_datapath.sv
// Testbench for gcd_datapath: a small controller closes the loop through
// INIT/COMPUTE/FINISH; a count-based model predicts every output each cycle.
module tb_gcd_datapath;
  localparam int WIDTH  = 16;
  localparam int ITER_W = 17;
  localparam int ITER_MAX = (1 << ITER_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  gcd_datapath_if #(.WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();

  gcd_datapath #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  // ---------------- counters / state ----------------
  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  int ctl_state = 0;  // 0 INIT, 1 COMPUTE, 2 FINISH
  bit ctl_auto  = 1'b1;
  bit accepted  = 1'b0;

  // model: loaded flag, enabled edges since load, total steps, gcd, latency
  bit m_loaded = 1'b0;
  int m_k = 0;
  int m_steps = 0;
  int m_gcd = 0;
  int m_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur within its cycle budget at %0t", name, $time);
  endtask

  // Euclid by division: each round of a/b subtractions ends with one swap.
  function automatic void euclid(input int unsigned a_in, input int unsigned b_in,
                                 output int unsigned g, output int unsigned s);
    int unsigned a, b, t;
    a = a_in;
    b = b_in;
    s = 0;
    while (b != 0) begin
      s = s + a / b + 1;
      t = a % b;
      a = b;
      b = t;
    end
    g = a;
  endfunction

  function automatic int exp_iter();
    int v;
    if (!m_loaded) return 0;
    v = m_k - 1;
    if (v < 0) v = 0;
    if (v > m_steps) v = m_steps;
    if (v > ITER_MAX) v = ITER_MAX;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin : compare
    int e_iter;
    bit e_ce, e_cz, e_rdy, e_val;
    int e_res;
    if (chk_on) begin
      e_iter = exp_iter();
      e_ce   = m_loaded && (e_iter < m_steps);
      e_cz   = m_loaded && !e_ce;
      e_rdy  = bus.flag_init_i && bus.gcd_enable_i && !m_loaded;
      e_val  = m_loaded && (m_k >= m_lat) && bus.flag_finish_i;
      e_res  = e_val ? m_gcd : 0;
      check("ready",        32'(bus.operand_ready_o),  32'(e_rdy));
      check("compute_en",   32'(bus.compute_enable_o), 32'(e_ce));
      check("compare_zero", 32'(bus.compare_zero_o),   32'(e_cz));
      check("result_valid", 32'(bus.result_valid_o),   32'(e_val));
      check("result",       32'(bus.result_o),         32'(e_res));
      check("iter_count",   32'(bus.iter_count_o),     32'(e_iter));
    end
  end

  // ---------------- driver tasks ----------------
  // One clock: snapshot inputs before the edge, then commit controller and
  // model state just after it.
  task automatic tick();
    int nxt, n_k, n_steps, n_gcd, n_lat;
    bit n_loaded, n_acc;
    int unsigned g, s;
    @(negedge clk_i);
    nxt = ctl_state; n_loaded = m_loaded; n_k = m_k;
    n_steps = m_steps; n_gcd = m_gcd; n_lat = m_lat; n_acc = 1'b0;
    if (reset_i) begin
      nxt = 0; n_loaded = 1'b0; n_k = 0; n_steps = 0; n_gcd = 0; n_lat = 0;
    end else if (bus.gcd_enable_i) begin
      if (ctl_state == 0) begin
        if (bus.compute_enable_o) nxt = 1;
        else if (bus.compare_zero_o) nxt = 2;
      end else if (ctl_state == 1) begin
        if (bus.compare_zero_o) nxt = 2;
      end
      if (!m_loaded) begin
        if (bus.operand_valid_i && bus.flag_init_i) begin
          euclid(32'(bus.operand_a_i), 32'(bus.operand_b_i), g, s);
          n_loaded = 1'b1; n_k = 0; n_steps = int'(s); n_gcd = int'(g);
          n_lat = (bus.operand_b_i == '0) ? 1 : int'(s) + 2;
          n_acc = 1'b1;
        end
      end else if (m_k < 1000000) begin
        n_k = m_k + 1;
      end
    end
    @(posedge clk_i);
    #1;
    ctl_state = nxt; m_loaded = n_loaded; m_k = n_k;
    m_steps = n_steps; m_gcd = n_gcd; m_lat = n_lat;
    if (n_acc) accepted = 1'b1;
    if (ctl_auto) begin
      bus.flag_init_i    = (ctl_state == 0);
      bus.flag_compute_i = (ctl_state == 1);
      bus.flag_finish_i  = (ctl_state == 2);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    ctl_auto = 1'b1;
    bus.gcd_enable_i = 1'b1;
    bus.operand_valid_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Load one pair, then run until result_valid_o; lat counts edges after load.
  task automatic run_op(input int a, input int b, input bit do_rst, input bit rnd_en,
                        input int gap_at, input int gap_len, output int lat, output bit ok);
    int n, budget;
    if (do_rst) do_reset();
    accepted = 1'b0;
    bus.operand_a_i = WIDTH'(a);
    bus.operand_b_i = WIDTH'(b);
    bus.operand_valid_i = 1'b1;
    n = 0;
    while (!accepted && n < 50) begin
      bus.gcd_enable_i = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    bus.operand_valid_i = 1'b0;
    lat = 0;
    ok = 1'b0;
    if (!accepted) begin
      note_fail("load_accept");
      bus.gcd_enable_i = 1'b1;
      return;
    end
    budget = 4 * m_lat + 64;
    for (int i = 0; i < budget; i++) begin
      #2;
      if (bus.result_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (rnd_en) bus.gcd_enable_i = ($urandom_range(0, 3) != 0);
      else bus.gcd_enable_i = !(gap_at >= 0 && i >= gap_at && i < gap_at + gap_len);
      tick();
      lat++;
    end
    if (!ok) note_fail("result_valid_wait");
    bus.gcd_enable_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int lat;
    bit ok;
    int unsigned g, s;

    reset_i = 1'b1;
    bus.gcd_enable_i = 1'b1;
    bus.flag_init_i = 1'b1;
    bus.flag_compute_i = 1'b0;
    bus.flag_finish_i = 1'b0;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    bus.operand_valid_i = 1'b0;

    // pin the model against hand-worked values
    euclid(12, 8, g, s);  check("model_12_8_gcd", g, 4);  check("model_12_8_steps", s, 5);
    euclid(48, 18, g, s); check("model_48_18_gcd", g, 6); check("model_48_18_steps", s, 8);
    euclid(0, 5, g, s);   check("model_0_5_steps", s, 1);
    euclid(9, 6, g, s);   check("model_9_6_gcd", g, 3);   check("model_9_6_steps", s, 5);

    do_reset();
    chk_on = 1'b1;
    #2;
    check("rst_ready", 32'(bus.operand_ready_o), 1);
    check("rst_result", 32'(bus.result_o), 0);
    check("rst_iter", 32'(bus.iter_count_o), 0);
    check("rst_cz", 32'(bus.compare_zero_o), 0);
    ctl_auto = 1'b0;
    bus.flag_init_i = 1'b0;
    #1;
    check("rst_ready_noinit", 32'(bus.operand_ready_o), 0);
    ctl_auto = 1'b1;
    bus.flag_init_i = 1'b1;

    // (12,8): five steps, valid 7 edges after load
    run_op(12, 8, 1'b1, 1'b0, -1, 0, lat, ok);
    check("d12_8_result", 32'(bus.result_o), 4);
    check("d12_8_iter", 32'(bus.iter_count_o), 5);
    check("d12_8_latency", 32'(lat), 7);

    // (7,0): straight to FINISH
    run_op(7, 0, 1'b1, 1'b0, -1, 0, lat, ok);
    check("d7_0_result", 32'(bus.result_o), 7);
    check("d7_0_iter", 32'(bus.iter_count_o), 0);
    check("d7_0_latency", 32'(lat), 1);

    // (0,0)
    run_op(0, 0, 1'b1, 1'b0, -1, 0, lat, ok);
    check("d0_0_result", 32'(bus.result_o), 0);
    check("d0_0_valid", 32'(bus.result_valid_o), 1);

    // (0,5): one swap, then a second valid pulse while in FINISH
    run_op(0, 5, 1'b1, 1'b0, -1, 0, lat, ok);
    check("d0_5_result", 32'(bus.result_o), 5);
    check("d0_5_iter", 32'(bus.iter_count_o), 1);
    ctl_auto = 1'b0;
    bus.flag_init_i = 1'b1;
    bus.operand_a_i = 16'd3;
    bus.operand_b_i = 16'd3;
    bus.operand_valid_i = 1'b1;
    repeat (3) tick();
    #2;
    check("repulse_ready", 32'(bus.operand_ready_o), 0);
    check("repulse_result", 32'(bus.result_o), 5);
    bus.operand_valid_i = 1'b0;
    ctl_auto = 1'b1;

    // (48,18) with a 3-cycle enable gap mid-COMPUTE
    run_op(48, 18, 1'b1, 1'b0, 3, 3, lat, ok);
    check("d48_18_result", 32'(bus.result_o), 6);
    check("d48_18_iter", 32'(bus.iter_count_o), 8);
    check("d48_18_latency", 32'(lat), 13);

    // reset mid-COMPUTE of (65535,1), then a fresh load without another reset
    do_reset();
    accepted = 1'b0;
    bus.operand_a_i = 16'hFFFF;
    bus.operand_b_i = 16'd1;
    bus.operand_valid_i = 1'b1;
    tick();
    bus.operand_valid_i = 1'b0;
    check("big_accepted", 32'(accepted), 1);
    repeat (10) tick();
    #2;
    check("big_iter_mid", 32'(bus.iter_count_o), 9);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #2;
    check("midrst_ready", 32'(bus.operand_ready_o), 1);
    check("midrst_ce", 32'(bus.compute_enable_o), 0);
    check("midrst_iter", 32'(bus.iter_count_o), 0);
    check("midrst_result", 32'(bus.result_o), 0);
    run_op(9, 6, 1'b0, 1'b0, -1, 0, lat, ok);
    check("d9_6_result", 32'(bus.result_o), 3);
    check("d9_6_iter", 32'(bus.iter_count_o), 5);

    // compute flag with nothing loaded
    do_reset();
    ctl_auto = 1'b0;
    bus.flag_init_i = 1'b0;
    bus.flag_compute_i = 1'b1;
    bus.flag_finish_i = 1'b0;
    repeat (4) tick();
    #2;
    check("noload_ce", 32'(bus.compute_enable_o), 0);
    check("noload_cz", 32'(bus.compare_zero_o), 0);
    check("noload_iter", 32'(bus.iter_count_o), 0);
    ctl_auto = 1'b1;

    // randomized operands with random enable gaps
    for (int t = 0; t < 12; t++) begin : rnd
      int unsigned ra, rb, rg, rs;
      int tries;
      tries = 0;
      do begin
        ra = $urandom_range(0, 65535);
        rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535);
        euclid(ra, rb, rg, rs);
        tries++;
      end while (rs > 600 && tries < 50);
      if (rs > 600) begin
        rb = ra;
        euclid(ra, rb, rg, rs);
      end
      run_op(int'(ra), int'(rb), 1'b1, 1'b1, -1, 0, lat, ok);
      if (ok) begin
        check("rand_result", 32'(bus.result_o), rg);
        check("rand_iter", 32'(bus.iter_count_o), rs);
      end
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // overall time bound
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
